// File: rtl/cnn_layer_seq_pkg.sv
// Shared definitions for the three-layer CNN tile sequencer:
// state encoding, layer/tile geometry and the per-layer tile table.
package cnn_layer_seq_pkg;

    localparam int NUM_LAYERS = 3;
    localparam int TW_DEF     = 5;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_LOAD  = 3'd2,
        S_CALC  = 3'd3,
        S_STORE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Tiles per layer: 16, 8, 4 (28 in total).
    function automatic int tiles_of(input logic [1:0] layer);
        case (layer)
            2'd0:    return 16;
            2'd1:    return 8;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/cnn_phase_wdog.sv
// Per-phase watchdog: counts cycles spent in one handshake phase and flags
// the cycle in which the count reaches TIMEOUT-1.
module cnn_phase_wdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = enable && (count == LIMIT);

endmodule

// File: rtl/cnn_layer_seq.sv
// Sequencer that walks three CNN layers tile by tile through
// load / compute / store handshakes, with a watchdog on each phase.
import cnn_layer_seq_pkg::*;

module cnn_layer_seq #(
    parameter int TIMEOUT = 4096,
    parameter int TW      = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    layer_id,
    output logic [TW-1:0] tile_idx,
    output logic          relu_en,
    output logic          ld_req,
    input  logic          ld_ack,
    output logic          calc_start,
    input  logic          calc_done,
    output logic          st_req,
    input  logic          st_ack,
    output state_t        fsm_state
);

    state_t state, state_next;
    logic   entry;
    logic   wd_clear, wd_enable, wd_timeout;
    logic   tile_last;

    assign tile_last = (tile_idx == TW'(tiles_of(layer_id) - 1));
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        ld_req     = 1'b0;
        st_req     = 1'b0;
        calc_start = 1'b0;
        wd_enable  = 1'b0;
        case (state)
            S_IDLE, S_ERR: begin
                busy = 1'b0;
                if (start) state_next = S_CFG;
            end
            S_CFG: state_next = S_LOAD;
            S_LOAD: begin
                ld_req    = 1'b1;
                wd_enable = 1'b1;
                if (ld_ack)          state_next = S_CALC;
                else if (wd_timeout) state_next = S_ERR;
            end
            S_CALC: begin
                // calc_done in the entry cycle belongs to no request of ours
                calc_start = entry;
                wd_enable  = 1'b1;
                if (calc_done && !entry) state_next = S_STORE;
                else if (wd_timeout)     state_next = S_ERR;
            end
            S_STORE: begin
                st_req    = 1'b1;
                wd_enable = 1'b1;
                if (st_ack)          state_next = S_NEXT;
                else if (wd_timeout) state_next = S_ERR;
            end
            S_NEXT: begin
                if (!tile_last)            state_next = S_LOAD;
                else if (layer_id == 2'd2) state_next = S_DONE;
                else                       state_next = S_CFG;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Restart the watchdog on every state change so each phase starts at 0.
    assign wd_clear = (state_next != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            entry    <= 1'b0;
            err      <= 1'b0;
            layer_id <= 2'd0;
            tile_idx <= '0;
            relu_en  <= 1'b0;
        end else begin
            state <= state_next;
            entry <= (state_next != state);
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        err      <= 1'b0;
                        layer_id <= 2'd0;
                        tile_idx <= '0;
                        relu_en  <= 1'b1;
                    end
                end
                S_CFG: tile_idx <= '0;
                S_LOAD, S_CALC, S_STORE: begin
                    if (state_next == S_ERR) begin
                        err     <= 1'b1;
                        relu_en <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (!tile_last) begin
                        tile_idx <= tile_idx + TW'(1);
                    end else if (layer_id != 2'd2) begin
                        layer_id <= layer_id + 2'd1;
                        tile_idx <= '0;
                        relu_en  <= (layer_id == 2'd0);
                    end
                end
                S_DONE: begin
                    layer_id <= 2'd0;
                    tile_idx <= '0;
                    relu_en  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    cnn_phase_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq: full runs, watchdog error and recovery,
// ack-at-timeout race, mid-run reset and held-start / stray calc_done.
module tb_cnn_layer_seq;
    import cnn_layer_seq_pkg::*;

    localparam int TO = 16;
    localparam int TWB = 5;

    logic clk = 1'b0;
    logic rst, start, ld_ack, calc_done, st_ack;
    logic busy, done, err, relu_en, ld_req, calc_start, st_req;
    logic [1:0]     layer_id;
    logic [TWB-1:0] tile_idx;
    state_t         fsm_state;

    int vec = 0, errs = 0;
    int cyc, done_cyc, n_done, n_ld, n_st, n_calc, n_relu0, st_cnt;
    int overlap = 0, relu_bad = 0, err_seen;
    bit ld_block = 0, st_target = 0, stray = 0, hold_start = 0, calc_pend = 0;

    always #5 clk = ~clk;

    cnn_layer_seq #(.TIMEOUT(TO), .TW(TWB)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .layer_id(layer_id), .tile_idx(tile_idx), .relu_en(relu_en),
        .ld_req(ld_req), .ld_ack(ld_ack), .calc_start(calc_start),
        .calc_done(calc_done), .st_req(st_req), .st_ack(st_ack), .fsm_state(fsm_state)
    );

    // One clock: record handshakes seen at the edge, then respond like the datapath.
    task automatic step();
        bit ld_hs, st_hs;
        ld_hs = ld_req && ld_ack;
        st_hs = st_req && st_ack;
        @(posedge clk);
        #1;
        cyc++;
        if (ld_hs) n_ld++;
        if (st_hs) n_st++;
        if (calc_start) n_calc++;
        if (err) err_seen++;
        if (done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = cyc;
            if (hold_start) begin
                start = 1'b0;
                hold_start = 0;
            end
        end
        if (({1'b0, ld_req} + {1'b0, st_req} + {1'b0, calc_start}) > 2'd1) overlap++;
        if (busy && (relu_en !== (layer_id != 2'd2))) relu_bad++;
        if (busy && !relu_en) n_relu0++;
        if (st_target && st_req && layer_id == 2'd0 && tile_idx == 5'd2) st_cnt++;
        ld_ack = !(ld_block && layer_id == 2'd1 && tile_idx == 5'd3);
        st_ack = !(st_target && st_req && layer_id == 2'd0 && tile_idx == 5'd2 && st_cnt < TO);
        calc_done = calc_pend || (stray && (ld_req || calc_start));
        calc_pend = calc_start;
    endtask

    task automatic kick();
        cyc = 0; done_cyc = 0; n_done = 0; n_ld = 0; n_st = 0; n_calc = 0;
        n_relu0 = 0; st_cnt = 0; err_seen = 0;
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
    endtask

    task automatic run_until_done();
        for (int i = 0; i < 400 && done_cyc == 0; i++) step();
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ld_ack = 1'b1; st_ack = 1'b1; calc_done = 1'b0;
        repeat (2) step();
        if ({busy, done, err, ld_req, st_req, calc_start, relu_en} !== 7'b0) begin
            errs++; $display("FAIL reset_flags: got %b expected 0000000",
                             {busy, done, err, ld_req, st_req, calc_start, relu_en});
        end
        vec++;
        if ({layer_id, tile_idx} !== 7'd0) begin
            errs++; $display("FAIL reset_idx: got layer %0d tile %0d expected 0 0", layer_id, tile_idx);
        end
        vec++;
        rst = 1'b0;
        step();
        if (busy !== 1'b0) begin
            errs++; $display("FAIL idle_no_start: busy %b expected 0", busy);
        end
        vec++;
    endtask

    task automatic test_full_run();
        kick();
        if (fsm_state !== S_CFG || busy !== 1'b1 || relu_en !== 1'b1) begin
            errs++; $display("FAIL first_cfg: state %0d busy %b relu %b expected CFG 1 1",
                             fsm_state, busy, relu_en);
        end
        vec++;
        run_until_done();
        if (done_cyc != 144) begin
            errs++; $display("FAIL full_latency: done in cycle %0d expected 144", done_cyc);
        end
        vec++;
        if (n_done != 1) begin
            errs++; $display("FAIL full_done_cnt: %0d expected 1", n_done);
        end
        vec++;
        if (n_ld != 28 || n_calc != 28 || n_st != 28) begin
            errs++; $display("FAIL full_handshakes: ld %0d calc %0d st %0d expected 28 each", n_ld, n_calc, n_st);
        end
        vec++;
        if (n_relu0 != 22) begin
            errs++; $display("FAIL full_relu0: %0d busy cycles with relu 0 expected 22", n_relu0);
        end
        vec++;
        if (busy !== 1'b0 || {layer_id, tile_idx} !== 7'd0) begin
            errs++; $display("FAIL full_return: busy %b layer %0d tile %0d expected 0 0 0", busy, layer_id, tile_idx);
        end
        vec++;
    endtask

    task automatic test_timeout();
        int lcnt;
        lcnt = 0;
        ld_block = 1;
        kick();
        for (int i = 0; i < 400 && !err; i++) begin
            step();
            if (ld_req && layer_id == 2'd1 && tile_idx == 5'd3) lcnt++;
        end
        if (lcnt != 16) begin
            errs++; $display("FAIL timeout_len: %0d cycles in LOAD expected 16", lcnt);
        end
        vec++;
        if ({err, busy, ld_req, st_req, calc_start} !== 5'b10000) begin
            errs++; $display("FAIL timeout_flags: err/busy/reqs %b expected 10000", {err, busy, ld_req, st_req, calc_start});
        end
        vec++;
        ld_block = 0;
        repeat (3) step();
        if (err !== 1'b1) begin
            errs++; $display("FAIL err_sticky: err %b expected 1", err);
        end
        vec++;
        kick();
        if (err !== 1'b0 || busy !== 1'b1 || layer_id !== 2'd0 || fsm_state !== S_CFG) begin
            errs++; $display("FAIL err_recover: err %b busy %b layer %0d state %0d expected 0 1 0 CFG",
                             err, busy, layer_id, fsm_state);
        end
        vec++;
        run_until_done();
        if (done_cyc != 144 || n_done != 1) begin
            errs++; $display("FAIL recover_run: done cycle %0d count %0d expected 144 1", done_cyc, n_done);
        end
        vec++;
    endtask

    task automatic test_ack_at_timeout();
        st_target = 1;
        kick();
        run_until_done();
        st_target = 0;
        if (st_cnt != TO) begin
            errs++; $display("FAIL store_len: %0d cycles in STORE expected %0d", st_cnt, TO);
        end
        vec++;
        if (err_seen != 0) begin
            errs++; $display("FAIL store_race_err: err seen in %0d cycles expected 0", err_seen);
        end
        vec++;
        if (done_cyc != 159 || n_st != 28) begin
            errs++; $display("FAIL store_race_run: done cycle %0d stores %0d expected 159 28", done_cyc, n_st);
        end
        vec++;
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        kick();
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (calc_start && layer_id == 2'd2) found = 1;
        end
        if (!found) begin
            errs++; $display("FAIL reach_l2_calc: not reached, got 0 expected 1");
        end
        vec++;
        rst = 1'b1;
        calc_pend = 0;
        calc_done = 1'b0;
        step();
        if ({busy, done, err, ld_req, st_req, calc_start, relu_en, layer_id, tile_idx} !== 14'd0) begin
            errs++; $display("FAIL midrst_outputs: got %b expected all zero",
                             {busy, done, err, ld_req, st_req, calc_start, relu_en, layer_id, tile_idx});
        end
        vec++;
        rst = 1'b0;
        repeat (8) step();
        if (n_done != 0 || busy !== 1'b0) begin
            errs++; $display("FAIL midrst_no_done: done %0d busy %b expected 0 0", n_done, busy);
        end
        vec++;
        kick();
        run_until_done();
        if (done_cyc != 144 || n_ld != 28 || n_calc != 28 || n_st != 28) begin
            errs++; $display("FAIL midrst_rerun: done cycle %0d ld %0d calc %0d st %0d expected 144 28 28 28",
                             done_cyc, n_ld, n_calc, n_st);
        end
        vec++;
    endtask

    task automatic test_back_to_back();
        hold_start = 1;
        stray = 1;
        kick();
        run_until_done();
        stray = 0;
        if (done_cyc != 144 || n_done != 1) begin
            errs++; $display("FAIL held_start_done: cycle %0d count %0d expected 144 1", done_cyc, n_done);
        end
        vec++;
        if (n_ld != 28 || n_calc != 28 || n_st != 28) begin
            errs++; $display("FAIL held_start_hs: ld %0d calc %0d st %0d expected 28 each", n_ld, n_calc, n_st);
        end
        vec++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            errs++; $display("FAIL held_start_idle: busy %b start %b expected 0 0", busy, start);
        end
        vec++;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_timeout();
        test_ack_at_timeout();
        test_mid_reset();
        test_back_to_back();
        if (overlap != 0) begin
            errs++; $display("FAIL req_overlap: %0d cycles expected 0", overlap);
        end
        vec++;
        if (relu_bad != 0) begin
            errs++; $display("FAIL relu_layer: %0d cycles expected 0", relu_bad);
        end
        vec++;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
